// File: rtl/stripe_pkg.sv
// -----------------------------------------------------------------------------
// stripe_pkg
// Shared definitions for the two-lane striping scheduler:
//   - state_t       : scheduler FSM states (IDLE / RUN / PAD)
//   - DATA_W_DEF    : default word width
//   - CREDITS_DEF   : default per-lane credit depth
//   - PAD_WORD_DEF  : default fill word for burst-end padding
//   - credit_width(): width of a counter that must hold 0..CREDITS
// -----------------------------------------------------------------------------
package stripe_pkg;

    localparam int          DATA_W_DEF   = 32;
    localparam int          CREDITS_DEF  = 4;
    localparam logic [31:0] PAD_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } state_t;

    // The counter has to represent CREDITS itself (a full lane), hence +1.
    function automatic int credit_width(input int credits);
        return (credits < 1) ? 1 : $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/stripe_sched_if.sv
// -----------------------------------------------------------------------------
// stripe_sched_if
// Bundles the stream handshake, credit returns and lane outputs of the
// striping scheduler.
//   master : word source / credit returner (drives data_in, valid_in,
//            credit_ret_0/1; observes everything else)
//   slave  : the scheduler itself
// Signals:
//   data_in, valid_in, ready_out      upstream valid/ready handshake
//   credit_ret_0, credit_ret_1        one-cycle credit return pulses
//   data_out0/1, valid_out_0/1        per-lane push data and strobe
//   lane_ptr                          lane that takes the next accepted word
//   credits_0, credits_1              per-lane credit counts
//   err_overflow                      sticky credit overflow flag
// -----------------------------------------------------------------------------
interface stripe_sched_if #(
    parameter int DATA_W  = 32,
    parameter int CREDITS = 4
);

    localparam int CW = stripe_pkg::credit_width(CREDITS);

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              credit_ret_0;
    logic              credit_ret_1;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out_0;
    logic              valid_out_1;
    logic              lane_ptr;
    logic [CW-1:0]     credits_0;
    logic [CW-1:0]     credits_1;
    logic              err_overflow;

    modport master (
        output data_in, valid_in, credit_ret_0, credit_ret_1,
        input  ready_out, data_out0, data_out1, valid_out_0, valid_out_1,
               lane_ptr, credits_0, credits_1, err_overflow
    );

    modport slave (
        input  data_in, valid_in, credit_ret_0, credit_ret_1,
        output ready_out, data_out0, data_out1, valid_out_0, valid_out_1,
               lane_ptr, credits_0, credits_1, err_overflow
    );

endinterface

// File: rtl/credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
// Per-lane credit tracker. Starts full (CREDITS), counts down on a push and
// up on a returned credit; a simultaneous push and return cancel out. A
// return into a full counter saturates and raises a sticky overflow flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       a word is pushed to this lane this cycle
//   i_ret        a credit is returned for this lane this cycle
//   o_count      current credit count
//   o_overflow   sticky overflow flag (cleared only by reset)
// -----------------------------------------------------------------------------
module credit_counter
    import stripe_pkg::*;
#(
    parameter  int CREDITS = CREDITS_DEF,
    localparam int CW      = credit_width(CREDITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_ret,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] r_count;
    logic          r_overflow;

    // The scheduler never pushes into an empty lane, so decrement needs no
    // underflow guard; only the increment side saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= FULL;
            r_overflow <= 1'b0;
        end else if (i_push && !i_ret) begin
            r_count <= r_count - CW'(1);
        end else if (i_ret && !i_push) begin
            if (r_count == FULL) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/stripe_sched.sv
// -----------------------------------------------------------------------------
// stripe_sched
// Two-lane striping scheduler. Accepted words are dealt to lane 0 and lane 1
// alternately, each lane gated by its own credit counter. Words appear on the
// lane outputs one cycle after acceptance, as a single-cycle strobe.
// Ports:
//   clk_2f    clock, all state on its rising edge
//   reset_L   asynchronous active-low reset
//   bus       stripe_sched_if.slave (handshake, credit returns, lane outputs,
//             credit counts, overflow flag)
// Build option:
//   STRIPE_PAD_EN  when defined, a burst that ends on an odd word count is
//                  followed by a PAD_WORD push on lane 1 so every burst is
//                  balanced and the next one starts on lane 0. When undefined,
//                  lane_ptr simply carries over into the next burst.
// -----------------------------------------------------------------------------
module stripe_sched
    import stripe_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                CREDITS  = CREDITS_DEF,
    parameter logic [DATA_W-1:0] PAD_WORD = DATA_W'(PAD_WORD_DEF)
) (
    input logic           clk_2f,
    input logic           reset_L,
    stripe_sched_if.slave bus
);

    localparam int CW = credit_width(CREDITS);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_lanePtr;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_valid0;
    logic              r_valid1;

    logic              w_ready;
    logic              w_accept;
    logic              w_padPush;
    logic              w_push0;
    logic              w_push1;
    logic [CW-1:0]     w_credits0;
    logic [CW-1:0]     w_credits1;
    logic              w_ovf0;
    logic              w_ovf1;

    // Ready only looks at the lane the next word is headed for; reset_L is
    // folded in so ready drops the instant reset asserts.
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_padPush   = 1'b0;
        w_push0     = 1'b0;
        w_push1     = 1'b0;

        w_ready   = (r_lanePtr ? (w_credits1 != '0) : (w_credits0 != '0))
                    && (r_state != PAD) && reset_L;
        w_accept  = bus.valid_in && w_ready;
        w_padPush = (r_state == PAD) && (w_credits1 != '0);
        w_push0   = w_accept && !r_lanePtr;
        w_push1   = (w_accept && r_lanePtr) || w_padPush;

        // A stall (valid with no ready) keeps RUN; only a gap in valid_in
        // ends the burst.
        case (r_state)
            IDLE: begin
                if (w_accept) w_nextState = RUN;
            end
            RUN: begin
                if (!bus.valid_in) begin
`ifdef STRIPE_PAD_EN
                    w_nextState = r_lanePtr ? PAD : IDLE;
`else
                    w_nextState = IDLE;
`endif
                end
            end
            PAD: begin
                if (w_padPush) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Lane registers: strobes are one-cycle, data holds between pushes.
    // The pad push re-aligns the alternation back to lane 0.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            r_data0   <= '0;
            r_data1   <= '0;
            r_valid0  <= 1'b0;
            r_valid1  <= 1'b0;
            r_lanePtr <= 1'b0;
        end else begin
            r_valid0 <= w_push0;
            r_valid1 <= w_push1;
            if (w_push0) r_data0 <= bus.data_in;
            if (w_push1) r_data1 <= w_padPush ? PAD_WORD : bus.data_in;
            if (w_padPush) begin
                r_lanePtr <= 1'b0;
            end else if (w_accept) begin
                r_lanePtr <= ~r_lanePtr;
            end
        end
    end

    credit_counter #(.CREDITS(CREDITS)) u_credit0 (
        .clk        (clk_2f),
        .rst_n      (reset_L),
        .i_push     (w_push0),
        .i_ret      (bus.credit_ret_0),
        .o_count    (w_credits0),
        .o_overflow (w_ovf0)
    );

    credit_counter #(.CREDITS(CREDITS)) u_credit1 (
        .clk        (clk_2f),
        .rst_n      (reset_L),
        .i_push     (w_push1),
        .i_ret      (bus.credit_ret_1),
        .o_count    (w_credits1),
        .o_overflow (w_ovf1)
    );

    assign bus.ready_out    = w_ready;
    assign bus.data_out0    = r_data0;
    assign bus.data_out1    = r_data1;
    assign bus.valid_out_0  = r_valid0;
    assign bus.valid_out_1  = r_valid1;
    assign bus.lane_ptr     = r_lanePtr;
    assign bus.credits_0    = w_credits0;
    assign bus.credits_1    = w_credits1;
    assign bus.err_overflow = w_ovf0 | w_ovf1;

endmodule

// File: tb/tb_stripe_sched.sv
// -----------------------------------------------------------------------------
// tb_stripe_sched
// Directed bench for stripe_sched (CREDITS=4). Inputs change 1 ns after each
// rising edge and outputs are sampled there too. Expected values are worked
// out by hand for each step; the odd-burst section has separate expectations
// depending on STRIPE_PAD_EN.
// -----------------------------------------------------------------------------
module tb_stripe_sched;

    logic clk_2f = 1'b0;
    logic reset_L;
    int   errors = 0;
    int   checks = 0;

    stripe_sched_if bus ();

    stripe_sched dut (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkLanes(input string tag, input logic v0, input logic [31:0] d0,
                              input logic v1, input logic [31:0] d1, input logic ptr);
        checkOutput({tag, ".valid_out_0"}, 32'(bus.valid_out_0), 32'(v0));
        checkOutput({tag, ".data_out0"},   bus.data_out0,        d0);
        checkOutput({tag, ".valid_out_1"}, 32'(bus.valid_out_1), 32'(v1));
        checkOutput({tag, ".data_out1"},   bus.data_out1,        d1);
        checkOutput({tag, ".lane_ptr"},    32'(bus.lane_ptr),    32'(ptr));
    endtask

    task automatic checkCredits(input string tag, input int c0, input int c1, input logic ovf);
        checkOutput({tag, ".credits_0"},    32'(bus.credits_0),    32'(c0));
        checkOutput({tag, ".credits_1"},    32'(bus.credits_1),    32'(c1));
        checkOutput({tag, ".err_overflow"}, 32'(bus.err_overflow), 32'(ovf));
    endtask

    task automatic checkReady(input string tag, input logic rdy);
        checkOutput({tag, ".ready_out"}, 32'(bus.ready_out), 32'(rdy));
    endtask

    // Present inputs for the coming edge, then return 1 ns after it.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic c0, input logic c1);
        bus.valid_in     = v;
        bus.data_in      = d;
        bus.credit_ret_0 = c0;
        bus.credit_ret_1 = c1;
        @(posedge clk_2f);
        #1;
    endtask

    initial begin
        bus.valid_in     = 1'b0;
        bus.data_in      = '0;
        bus.credit_ret_0 = 1'b0;
        bus.credit_ret_1 = 1'b0;
        reset_L          = 1'b1;
        #2;
        reset_L = 1'b0;

        // ---------------- reset ----------------
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkLanes("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkCredits("reset", 4, 4, 1'b0);
        checkReady("reset", 1'b0);
        reset_L = 1'b1;
        #1;
        checkReady("reset_release", 1'b1);

        // ---------------- even burst ----------------
        applyStimulus(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
        checkLanes("even1", 1'b1, 32'hEEEE_EEEE, 1'b0, 32'h0, 1'b1);
        checkCredits("even1", 3, 4, 1'b0);
        applyStimulus(1'b1, 32'hEEEE_EEEF, 1'b1, 1'b0);
        checkLanes("even2", 1'b0, 32'hEEEE_EEEE, 1'b1, 32'hEEEE_EEEF, 1'b0);
        checkCredits("even2", 4, 3, 1'b0);
        applyStimulus(1'b1, 32'hEEEE_EEF0, 1'b0, 1'b1);
        checkLanes("even3", 1'b1, 32'hEEEE_EEF0, 1'b0, 32'hEEEE_EEEF, 1'b1);
        checkCredits("even3", 3, 4, 1'b0);
        applyStimulus(1'b1, 32'hEEEE_EEF1, 1'b1, 1'b0);
        checkLanes("even4", 1'b0, 32'hEEEE_EEF0, 1'b1, 32'hEEEE_EEF1, 1'b0);
        checkCredits("even4", 4, 3, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkLanes("even_end", 1'b0, 32'hEEEE_EEF0, 1'b0, 32'hEEEE_EEF1, 1'b0);
        checkCredits("even_end", 4, 4, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkLanes("even_nopad", 1'b0, 32'hEEEE_EEF0, 1'b0, 32'hEEEE_EEF1, 1'b0);

        // ---------------- odd burst ----------------
        applyStimulus(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
        checkLanes("odd1", 1'b1, 32'hEEEE_EEEE, 1'b0, 32'hEEEE_EEF1, 1'b1);
        applyStimulus(1'b1, 32'hEEEE_EEEF, 1'b1, 1'b0);
        checkLanes("odd2", 1'b0, 32'hEEEE_EEEE, 1'b1, 32'hEEEE_EEEF, 1'b0);
        applyStimulus(1'b1, 32'hEEEE_EEF0, 1'b0, 1'b1);
        checkLanes("odd3", 1'b1, 32'hEEEE_EEF0, 1'b0, 32'hEEEE_EEEF, 1'b1);
        checkCredits("odd3", 3, 4, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkLanes("odd_end", 1'b0, 32'hEEEE_EEF0, 1'b0, 32'hEEEE_EEEF, 1'b1);
        checkCredits("odd_end", 4, 4, 1'b0);
`ifdef STRIPE_PAD_EN
        checkReady("pad_stall", 1'b0);
        applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        checkLanes("pad_push", 1'b0, 32'hEEEE_EEF0, 1'b1, 32'h0000_0000, 1'b0);
        checkCredits("pad_push", 4, 3, 1'b0);
        applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        checkLanes("pad_next1", 1'b1, 32'h2222_2222, 1'b0, 32'h0000_0000, 1'b1);
        applyStimulus(1'b1, 32'h3333_3333, 1'b1, 1'b0);
        checkLanes("pad_next2", 1'b0, 32'h2222_2222, 1'b1, 32'h3333_3333, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkCredits("pad_done", 4, 4, 1'b0);
`else
        checkReady("nopad_ready", 1'b1);
        applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        checkLanes("nopad_next", 1'b0, 32'hEEEE_EEF0, 1'b1, 32'h1111_1111, 1'b0);
        checkCredits("nopad_next", 4, 3, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkCredits("nopad_done", 4, 4, 1'b0);
`endif

        // ---------------- credit exhaustion ----------------
        for (int k = 0; k < 8; k++) begin
            checkReady($sformatf("exh%0d", k), 1'b1);
            applyStimulus(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
            if (k % 2 == 0) begin
                checkOutput($sformatf("exh%0d.valid_out_0", k), 32'(bus.valid_out_0), 32'd1);
                checkOutput($sformatf("exh%0d.data_out0", k), bus.data_out0, 32'h100 + 32'(k));
                checkOutput($sformatf("exh%0d.valid_out_1", k), 32'(bus.valid_out_1), 32'd0);
            end else begin
                checkOutput($sformatf("exh%0d.valid_out_1", k), 32'(bus.valid_out_1), 32'd1);
                checkOutput($sformatf("exh%0d.data_out1", k), bus.data_out1, 32'h100 + 32'(k));
                checkOutput($sformatf("exh%0d.valid_out_0", k), 32'(bus.valid_out_0), 32'd0);
            end
            checkCredits($sformatf("exh%0d", k), 4 - (k + 2) / 2, 4 - (k + 1) / 2, 1'b0);
        end
        checkReady("exh_empty", 1'b0);
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
            checkOutput($sformatf("stall%0d.valid_out_0", s), 32'(bus.valid_out_0), 32'd0);
            checkOutput($sformatf("stall%0d.valid_out_1", s), 32'(bus.valid_out_1), 32'd0);
            checkReady($sformatf("stall%0d", s), 1'b0);
        end
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        checkOutput("ret0.valid_out_0", 32'(bus.valid_out_0), 32'd0);
        checkCredits("ret0", 1, 0, 1'b0);
        checkReady("ret0", 1'b1);
        applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
        checkLanes("ninth", 1'b1, 32'h108, 1'b0, 32'h107, 1'b1);
        checkCredits("ninth", 0, 0, 1'b0);
        checkReady("ninth", 1'b0);
        applyStimulus(1'b1, 32'h109, 1'b0, 1'b1);
        checkOutput("ret1.valid_out_1", 32'(bus.valid_out_1), 32'd0);
        checkReady("ret1", 1'b1);
        applyStimulus(1'b1, 32'h109, 1'b0, 1'b0);
        checkLanes("tenth", 1'b0, 32'h108, 1'b1, 32'h109, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkCredits("refill", 4, 4, 1'b0);

        // ---------------- credit corner cases ----------------
        applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0);
        checkCredits("cc1", 3, 4, 1'b0);
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        checkCredits("cc2", 3, 3, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b1, 1'b0);
        checkLanes("cc_pushret0", 1'b1, 32'hA2, 1'b0, 32'hA1, 1'b1);
        checkCredits("cc_pushret0", 3, 3, 1'b0);
        applyStimulus(1'b1, 32'hA3, 1'b0, 1'b1);
        checkLanes("cc_pushret1", 1'b0, 32'hA2, 1'b1, 32'hA3, 1'b0);
        checkCredits("cc_pushret1", 3, 3, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkCredits("cc_full", 4, 4, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkCredits("cc_overflow", 4, 4, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkCredits("cc_sticky", 4, 4, 1'b1);

        // ---------------- reset mid-burst ----------------
        applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0);
        checkLanes("mid_pre", 1'b0, 32'hB0, 1'b1, 32'hB1, 1'b0);
        checkCredits("mid_pre", 3, 3, 1'b1);
        reset_L      = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        checkLanes("mid_async", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkCredits("mid_async", 4, 4, 1'b0);
        checkReady("mid_async", 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset_L = 1'b1;
        #1;
        checkReady("mid_release", 1'b1);
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0);
        checkLanes("mid_first", 1'b1, 32'hC0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
        checkLanes("mid_second", 1'b0, 32'hC0, 1'b1, 32'hC1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stripe_sched.md
# stripe_sched

Two-lane striping scheduler for the demux striping datapath. It accepts a 32-bit word stream with a valid/ready handshake and assigns words to lane 0 and lane 1 alternately. Each lane is gated by a per-lane credit counter that reflects free space in the downstream lane buffer. The block sits between the upstream word source and the per-lane buffers, and it owns lane order, flow control and burst-end balancing.

## Interface
- `DATA_W`, 32, word width.
- `CREDITS`, 4, per-lane credit depth, meaning the downstream buffer slots per lane; must be ≥1.
- `PAD_WORD`, 32'h0000_0000, fill word used when padding is compiled in.

- `clk_2f` in 1: single clock; all state updates on its rising edge.
- `reset_L` in 1: reset, asynchronous, active-low.
- `data_in` in DATA_W: input word.
- `valid_in` in 1: `data_in` is valid.
- `ready_out` out 1: the block accepts the word this cycle.
- `credit_ret_0` in 1: one-cycle pulse returning one lane-0 credit.
- `credit_ret_1` in 1: one-cycle pulse returning one lane-1 credit.
- `data_out0` out DATA_W: lane-0 word.
- `data_out1` out DATA_W: lane-1 word.
- `valid_out_0` out 1: lane-0 push strobe.
- `valid_out_1` out 1: lane-1 push strobe.
- `lane_ptr` out 1: lane that receives the next accepted word.
- `credits_0` out $clog2(CREDITS+1): lane-0 credit count.
- `credits_1` out $clog2(CREDITS+1): lane-1 credit count.
- `err_overflow` out 1: sticky flag set when a credit is returned to a full counter.

## Operation
- **Accept:** a word is accepted when `valid_in && ready_out`.
  - `ready_out = (credits[lane_ptr] != 0) && state != PAD && reset_L`. It is combinational.
- **Routing:** an accepted word goes to lane `lane_ptr`.
  - That lane's `data_outN` is registered with the word and `valid_out_N` is set to 1.
  - That lane's credit decrements.
  - `lane_ptr` toggles.
- **Lane idle:** in any cycle with no push to a lane, that lane's `valid_out_N` is 0 and its `data_outN` holds its last value.
- **Credits:**
  - Push without return: count − 1.
  - Return without push: count + 1.
  - Push and return in the same cycle: count unchanged.
  - Return while count == CREDITS: count saturates, and `err_overflow` is set to 1 and held until reset.
- **FSM states:** IDLE, RUN, PAD.
  - IDLE→RUN on the first accepted word.
  - RUN→IDLE on the first cycle with `valid_in`=0. This ends the burst.
  - A cycle with `valid_in`=1 and `ready_out`=0 is a stall. It is not a burst end.
  - RUN→PAD instead of IDLE when the burst ended with `lane_ptr`==1 (odd word count) and `STRIPE_PAD_EN` is defined.
  - PAD→IDLE on the cycle where `credits_1` > 0. In that cycle the block pushes `PAD_WORD` on lane 1, decrements `credits_1` and sets `lane_ptr` to 0.
  - In PAD, `ready_out` is 0. Input arriving during PAD stalls.
- **Reset values:** all data and valid outputs 0, `lane_ptr`=0, both credit counts = CREDITS, `err_overflow`=0, state IDLE.
  - Reset mid-burst discards in-flight state immediately, asynchronously.

## Timing
- Latency is 1 cycle. A word accepted at edge k appears on `data_outN`/`valid_out_N` immediately after edge k, for one cycle.
- Throughput is 1 word per cycle total across both lanes. Each lane pushes at most every other cycle unless stalled.
- Credits take effect 1 cycle after return: a `credit_ret` sampled at edge k can enable `ready_out` in cycle k+1.
- `ready_out` drops in the cycle where the lane selected by `lane_ptr` has 0 credits. The other lane's credits do not matter.
- The pad push completes 1 cycle after the burst end if lane-1 credit is available. Otherwise it waits for a lane-1 credit.

## Configuration
- `STRIPE_PAD_EN` defined: odd bursts are padded so that every burst places an equal number of words on both lanes, and every burst starts on lane 0.
- `STRIPE_PAD_EN` undefined: the PAD state is unreachable and `lane_ptr` persists across bursts, so the next burst continues on the next lane in the alternation.

## Structure
- Package `stripe_pkg` holds:
  - the state enum (IDLE/RUN/PAD);
  - DATA_W and PAD_WORD defaults;
  - the credit-width constant/function.
- Sub-module `credit_counter` is instantiated once per lane. It provides saturating up/down counting, simultaneous push/return handling and the overflow flag output. The top level ORs the two overflow flags into `err_overflow`.

## Test plan
- **Reset:** hold `reset_L`=0 for 3 cycles, then release.
  - During reset: all outputs 0, `credits_0`=`credits_1`=4, `ready_out`=0.
  - After release: `ready_out`=1.
- **Even burst:** send 4 words 0xEEEEEEEE..0xEEEEEEF1, with credits returned 1 cycle after each push.
  - Lane 0 receives 0xEEEEEEEE and 0xEEEEEEF0. Lane 1 receives 0xEEEEEEEF and 0xEEEEEEF1.
  - The valid strobes alternate, `lane_ptr`=0 afterwards, and no pad is inserted.
- **Odd burst:** send 3 words 0xEEEEEEEE..0xEEEEEEF0.
  - With `STRIPE_PAD_EN`: lane 1 receives 0x00000000 one cycle after the burst end, then `lane_ptr`=0.
  - Without `STRIPE_PAD_EN`: no pad, `lane_ptr`=1, and the next burst's first word goes to lane 1.
- **Credit exhaustion:** hold `valid_in`=1 for 10 words with no credit returns.
  - Exactly 8 words are accepted and `ready_out`=0 from the 9th.
  - One `credit_ret_0` pulse → the 9th word is accepted on lane 0 in the next cycle.
- **Credit corner cases:**
  - A lane-0 push and `credit_ret_0` in the same cycle → `credits_0` is unchanged.
  - `credit_ret_1` while `credits_1`=4 → `credits_1` stays 4 and `err_overflow`=1, held until reset.
- **Reset mid-burst:** assert `reset_L`=0 after 2 accepted words.
  - All outputs are 0 immediately, without waiting for a clock edge, and both counts are 4.
  - After release, the first word goes to lane 0.
